// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage MIPS pipeline: issues loads and stores over a
// request/acknowledge data-memory port, stalls upstream while busy, and owns the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        e_valid,
  input  logic [31:0] e_alu,
  input  logic [31:0] e_b,
  input  logic        e_wmem,
  input  logic        e_m2reg,
  input  logic        e_wreg,
  input  logic [4:0]  e_rn,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] w_r_alu,
  output logic [31:0] w_m_o,
  output logic        w_m2reg,
  output logic        w_wreg,
  output logic [4:0]  w_rn,
  output logic        w_exc
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          ld_q, ld_d;
  logic          wreg_q, wreg_d;
  logic [4:0]    rn_q, rn_d;

  logic [31:0]   w_r_alu_q, w_r_alu_d;
  logic [31:0]   w_m_o_q, w_m_o_d;
  logic          w_m2reg_q, w_m2reg_d;
  logic          w_wreg_q, w_wreg_d;
  logic [4:0]    w_rn_q, w_rn_d;
  logic          w_exc_q, w_exc_d;

  logic          mem_op;
  logic          misalign;

  assign mem_op   = e_valid & (e_wmem | e_m2reg);
  assign misalign = mem_op & (e_alu[1:0] != 2'b00);

  // MEM/WB defaults to an all-zero bubble; only retiring instructions overwrite it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    ld_d      = ld_q;
    wreg_d    = wreg_q;
    rn_d      = rn_q;
    w_r_alu_d = 32'h0;
    w_m_o_d   = 32'h0;
    w_m2reg_d = 1'b0;
    w_wreg_d  = 1'b0;
    w_rn_d    = 5'd0;
    w_exc_d   = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (misalign) begin
          w_exc_d = 1'b1;
        end else if (mem_op) begin
          stall   = 1'b1;
          addr_d  = e_alu;
          wdata_d = e_b;
          we_d    = e_wmem;
          ld_d    = e_m2reg;
          wreg_d  = e_wreg;
          rn_d    = e_rn;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          w_r_alu_d = e_alu;
          w_wreg_d  = e_valid & e_wreg;
          w_rn_d    = e_rn;
        end
      end
      BUSY: begin
        // An ack in the timeout cycle wins over the abort.
        if (dm_ack) begin
          w_r_alu_d = addr_q;
          w_m_o_d   = we_q ? 32'h0 : dm_rdata;
          w_m2reg_d = ld_q & ~we_q;
          w_wreg_d  = wreg_q & ~we_q;
          w_rn_d    = rn_q;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          w_exc_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      we_q      <= 1'b0;
      ld_q      <= 1'b0;
      wreg_q    <= 1'b0;
      rn_q      <= 5'd0;
      w_r_alu_q <= 32'h0;
      w_m_o_q   <= 32'h0;
      w_m2reg_q <= 1'b0;
      w_wreg_q  <= 1'b0;
      w_rn_q    <= 5'd0;
      w_exc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      ld_q      <= ld_d;
      wreg_q    <= wreg_d;
      rn_q      <= rn_d;
      w_r_alu_q <= w_r_alu_d;
      w_m_o_q   <= w_m_o_d;
      w_m2reg_q <= w_m2reg_d;
      w_wreg_q  <= w_wreg_d;
      w_rn_q    <= w_rn_d;
      w_exc_q   <= w_exc_d;
    end
  end

  // Request is high exactly while BUSY; the latched fields cannot change then.
  assign dm_req   = (state_q == BUSY);
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;

  assign w_r_alu  = w_r_alu_q;
  assign w_m_o    = w_m_o_q;
  assign w_m2reg  = w_m2reg_q;
  assign w_wreg   = w_wreg_q;
  assign w_rn     = w_rn_q;
  assign w_exc    = w_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written multi-cycle
// sequences for loads, stores, timeout, ack-at-timeout and reset during an access.
module tb_mem_stage;

  logic        clk;
  logic        clrn;
  logic        e_valid;
  logic [31:0] e_alu;
  logic [31:0] e_b;
  logic        e_wmem;
  logic        e_m2reg;
  logic        e_wreg;
  logic [4:0]  e_rn;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] w_r_alu;
  logic [31:0] w_m_o;
  logic        w_m2reg;
  logic        w_wreg;
  logic [4:0]  w_rn;
  logic        w_exc;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .clrn(clrn),
    .e_valid(e_valid), .e_alu(e_alu), .e_b(e_b), .e_wmem(e_wmem),
    .e_m2reg(e_m2reg), .e_wreg(e_wreg), .e_rn(e_rn),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall(stall),
    .w_r_alu(w_r_alu), .w_m_o(w_m_o), .w_m2reg(w_m2reg), .w_wreg(w_wreg),
    .w_rn(w_rn), .w_exc(w_exc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] r_alu, input logic [31:0] m_o,
                        input logic m2reg, input logic wreg, input logic [4:0] rn, input logic exc);
    chk({tag, ".w_r_alu"}, w_r_alu, r_alu);
    chk({tag, ".w_m_o"},   w_m_o,   m_o);
    chk({tag, ".w_m2reg"}, 32'(w_m2reg), 32'(m2reg));
    chk({tag, ".w_wreg"},  32'(w_wreg),  32'(wreg));
    chk({tag, ".w_rn"},    32'(w_rn),    32'(rn));
    chk({tag, ".w_exc"},   32'(w_exc),   32'(exc));
  endtask

  task automatic drive_idle();
    @(negedge clk);
    e_valid = 1'b0;
    e_wmem  = 1'b0;
    e_m2reg = 1'b0;
    e_wreg  = 1'b0;
    dm_ack  = 1'b0;
  endtask

  // Runs one memory instruction until stall drops; ack_cyc = 0 means the memory never acks.
  // Returns after the edge that retires it, with MEM/WB outputs ready to check.
  task automatic mem_access(input string tag, input logic [31:0] alu, input logic [31:0] b,
                            input logic we, input logic ld, input logic wr, input logic [4:0] rn,
                            input int ack_cyc, input logic [31:0] rdata,
                            output int stall_cnt, output int req_cnt);
    bit done;
    stall_cnt = 0;
    req_cnt   = 0;
    done      = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        e_valid = 1'b1; e_alu = alu; e_b = b;
        e_wmem = we; e_m2reg = ld; e_wreg = wr; e_rn = rn;
      end
      dm_ack   = (ack_cyc > 0) && (c == ack_cyc);
      dm_rdata = dm_ack ? rdata : $urandom;
      #1;
      if (stall) stall_cnt++;
      else done = 1'b1;
      if (dm_req) begin
        req_cnt++;
        chk({tag, ".dm_addr"},  dm_addr,  alu);
        chk({tag, ".dm_wdata"}, dm_wdata, b);
        chk({tag, ".dm_we"},    32'(dm_we), 32'(we));
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s.timeout: stall still high after 40 cycles, expected release", tag);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic        wmem;
    logic        m2reg;
    logic        wreg;
    logic [4:0]  rn;
    logic        ack;
    logic        x_stall;
    logic [31:0] x_r_alu;
    logic        x_wreg;
    logic [4:0]  x_rn;
    logic        x_exc;
  } vec_t;

  vec_t vecs[7];
  int   sc, rc;

  initial begin
    clrn = 1'b0; e_valid = 1'b0; e_alu = '0; e_b = '0; e_wmem = 1'b0;
    e_m2reg = 1'b0; e_wreg = 1'b0; e_rn = '0; dm_ack = 1'b0; dm_rdata = '0;

    //                 valid alu           wmem m2r wreg rn  ack  stall r_alu        wreg rn  exc
    vecs[0] = '{1'b1, 32'h1,        1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 32'h1,        1'b1, 5'd3,  1'b0};
    vecs[1] = '{1'b0, 32'h55,       1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 32'h55,       1'b0, 5'd7,  1'b0};
    vecs[2] = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 5'd31, 1'b0};
    vecs[3] = '{1'b1, 32'h13,       1'b0, 1'b1, 1'b1, 5'd4,  1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1};
    vecs[4] = '{1'b1, 32'h8,        1'b0, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 32'h8,        1'b1, 5'd2,  1'b0};
    vecs[5] = '{1'b1, 32'h22,       1'b1, 1'b0, 1'b0, 5'd9,  1'b0, 1'b0, 32'h0,        1'b0, 5'd0,  1'b1};
    vecs[6] = '{1'b0, 32'h13,       1'b0, 1'b1, 1'b1, 5'd6,  1'b0, 1'b0, 32'h13,       1'b0, 5'd6,  1'b0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.dm_req", 32'(dm_req), 32'h0);
    chk("rst.dm_we", 32'(dm_we), 32'h0);
    chk("rst.dm_addr", dm_addr, 32'h0);
    chk("rst.dm_wdata", dm_wdata, 32'h0);
    chk("rst.stall", 32'(stall), 32'h0);
    chk_wb("rst", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    clrn = 1'b1;

    // single-cycle vectors: pass-through ops, ack ignored in IDLE, misaligned accesses
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      e_valid = vecs[i].valid; e_alu = vecs[i].alu; e_b = $urandom;
      e_wmem = vecs[i].wmem; e_m2reg = vecs[i].m2reg; e_wreg = vecs[i].wreg;
      e_rn = vecs[i].rn; dm_ack = vecs[i].ack; dm_rdata = $urandom;
      #1;
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].x_stall));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.dm_req", i), 32'(dm_req), 32'h0);
      chk_wb($sformatf("vec%0d", i), vecs[i].x_r_alu, 32'h0, 1'b0, vecs[i].x_wreg,
             vecs[i].x_rn, vecs[i].x_exc);
    end
    drive_idle();

    // load acked in the first BUSY cycle
    mem_access("ld1", 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 1, 32'h2, sc, rc);
    chk_wb("ld1", 32'h10, 32'h2, 1'b1, 1'b1, 5'd5, 1'b0);
    chk("ld1.stall_cycles", sc, 1);
    chk("ld1.req_cycles", rc, 1);
    chk("ld1.req_drop", 32'(dm_req), 32'h0);

    // store acked after 3 BUSY cycles, followed back-to-back by a load
    mem_access("st", 32'h20, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 5'd8, 3, 32'h12345678, sc, rc);
    chk_wb("st", 32'h20, 32'h0, 1'b0, 1'b0, 5'd8, 1'b0);
    chk("st.stall_cycles", sc, 3);
    chk("st.req_cycles", rc, 3);
    mem_access("ld2", 32'h24, 32'h0, 1'b0, 1'b1, 1'b1, 5'd12, 2, 32'hCAFEF00D, sc, rc);
    chk_wb("ld2", 32'h24, 32'hCAFEF00D, 1'b1, 1'b1, 5'd12, 1'b0);
    chk("ld2.stall_cycles", sc, 2);

    // no ack: abort after 16 request cycles
    mem_access("to", 32'h30, 32'h0, 1'b0, 1'b1, 1'b1, 5'd1, 0, 32'h0, sc, rc);
    chk_wb("to", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    chk("to.req_cycles", rc, 16);
    chk("to.stall_cycles", sc, 16);
    chk("to.req_drop", 32'(dm_req), 32'h0);
    drive_idle();
    @(posedge clk);
    #1;
    chk("to.exc_single", 32'(w_exc), 32'h0);

    // ack in the timeout cycle counts as success
    mem_access("ackto", 32'h34, 32'h0, 1'b0, 1'b1, 1'b1, 5'd14, 16, 32'h77, sc, rc);
    chk_wb("ackto", 32'h34, 32'h77, 1'b1, 1'b1, 5'd14, 1'b0);
    chk("ackto.req_cycles", rc, 16);

    // reset in the middle of BUSY
    @(negedge clk);
    e_valid = 1'b1; e_alu = 32'h40; e_b = 32'h0; e_wmem = 1'b0; e_m2reg = 1'b1;
    e_wreg = 1'b1; e_rn = 5'd10; dm_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstbusy.req_before", 32'(dm_req), 32'h1);
    e_valid = 1'b0;
    clrn = 1'b0;
    #1;
    chk("rstbusy.dm_req", 32'(dm_req), 32'h0);
    chk("rstbusy.dm_addr", dm_addr, 32'h0);
    chk_wb("rstbusy", 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    mem_access("ld3", 32'h44, 32'h0, 1'b0, 1'b1, 1'b1, 5'd11, 2, 32'hABCD, sc, rc);
    chk_wb("ld3", 32'h44, 32'hABCD, 1'b1, 1'b1, 5'd11, 1'b0);
    chk("ld3.stall_cycles", sc, 2);
    drive_idle();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
